// File: rtl/mem_axi_master_ctrl_if.sv
// AXI4-Lite channel bundle between the MEM-stage master controller and the interconnect.
// valid/ready: a beat transfers on any rising clk edge where both are high; valid never drops before that.
interface mem_axi_master_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic                  m_awvalid;
  logic                  m_awready;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wstrb;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [1:0]            m_bresp;
  logic                  m_bvalid;
  logic                  m_bready;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [31:0]           m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rvalid;
  logic                  m_rready;

  modport master (
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_araddr, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid,
    input  m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_araddr, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid,
    output m_arready, m_rdata, m_rresp, m_rvalid
  );
endinterface

// File: rtl/mem_axi_master_ctrl.sv
// MEM-stage AXI4-Lite master: one load/store becomes one AXI read or write; stalls the pipe until done.
// State is exported on dbg_state (0 IDLE, 1 WR, 2 WR_RESP, 3 RD_ADDR, 4 RD_DATA, 5 DONE).
module mem_axi_master_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  input  logic [1:0]            store_type,
  input  logic [2:0]            load_type,
  output logic                  stall,
  output logic [31:0]           read_data,
  output logic                  bus_err,
  output logic [2:0]            dbg_state,
  mem_axi_master_ctrl_if.master m_axi
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            off_q;
  logic [2:0]            ltype_q;
  logic [31:0]           wdata_q, rdata_q, read_data_q;
  logic [3:0]            wstrb_q;
  logic [1:0]            resp_q;
  logic                  is_load_q, aw_done_q, w_done_q, err_pulse_q;

  logic        request, misaligned, accept;
  logic        awvalid, wvalid, bready, arvalid, rready, aw_hs, w_hs;
  logic [31:0] wdata_gen, load_val;
  logic [3:0]  wstrb_gen;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Requests are ignored while reset is held so the pipe is never stalled by a reset-time request.
  assign request = rst & (mem_read | mem_write);

  always_comb begin
    misaligned = 1'b0;
    wdata_gen  = store_data;
    wstrb_gen  = 4'b1111;
    if (mem_write) begin
      case (store_type)
        2'b00: begin
          wdata_gen = {4{store_data[7:0]}};
          wstrb_gen = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          misaligned = addr[0];
          wdata_gen  = {2{store_data[15:0]}};
          wstrb_gen  = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: misaligned = |addr[1:0];
      endcase
    end else begin
      case (load_type)
        3'b001, 3'b100: misaligned = addr[0];
        3'b010:         misaligned = |addr[1:0];
        default:        misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    accept  = 1'b0;
    awvalid = (state_q == S_WR) & ~aw_done_q;
    wvalid  = (state_q == S_WR) & ~w_done_q;
    bready  = (state_q == S_WR_RESP);
    arvalid = (state_q == S_RD_ADDR);
    rready  = (state_q == S_RD_DATA);
    aw_hs   = awvalid & m_axi.m_awready;
    w_hs    = wvalid & m_axi.m_wready;
    case (state_q)
      S_IDLE: begin
        if (request && !misaligned) begin
          stall   = 1'b1;
          accept  = 1'b1;
          state_d = mem_write ? S_WR : S_RD_ADDR;
        end
      end
      S_WR: begin
        stall = 1'b1;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        stall = 1'b1;
        if (m_axi.m_bvalid) state_d = S_DONE;
      end
      S_RD_ADDR: begin
        stall = 1'b1;
        if (m_axi.m_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        stall = 1'b1;
        if (m_axi.m_rvalid) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign byte_sel = rdata_q[{off_q, 3'b000} +: 8];
  assign half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    case (ltype_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b011:  load_val = {24'd0, byte_sel};
      3'b100:  load_val = {16'd0, half_sel};
      default: load_val = rdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      off_q       <= 2'b00;
      ltype_q     <= 3'b000;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      rdata_q     <= 32'd0;
      resp_q      <= 2'b00;
      read_data_q <= 32'd0;
      is_load_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_pulse_q <= (state_q == S_IDLE) & request & misaligned;
      if (accept) begin
        addr_q    <= {addr[ADDR_WIDTH-1:2], 2'b00};
        off_q     <= addr[1:0];
        ltype_q   <= load_type;
        wdata_q   <= wdata_gen;
        wstrb_q   <= wstrb_gen;
        is_load_q <= ~mem_write;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (bready && m_axi.m_bvalid) resp_q <= m_axi.m_bresp;
      if (rready && m_axi.m_rvalid) begin
        rdata_q <= m_axi.m_rdata;
        resp_q  <= m_axi.m_rresp;
      end
      if (state_q == S_DONE && is_load_q) read_data_q <= (resp_q != 2'b00) ? 32'd0 : load_val;
    end
  end

  assign read_data = read_data_q;
  assign bus_err   = err_pulse_q | ((state_q == S_DONE) & (resp_q != 2'b00));
  assign dbg_state = state_q;

  assign m_axi.m_awaddr  = addr_q;
  assign m_axi.m_araddr  = addr_q;
  assign m_axi.m_wdata   = wdata_q;
  assign m_axi.m_wstrb   = wstrb_q;
  assign m_axi.m_awvalid = awvalid;
  assign m_axi.m_wvalid  = wvalid;
  assign m_axi.m_bready  = bready;
  assign m_axi.m_arvalid = arvalid;
  assign m_axi.m_rready  = rready;

endmodule

// File: doc/mem_axi_master_ctrl.md
Name: mem_axi_master_ctrl

Overview:
- AXI4-Lite master controller sitting between the MEM stage and the SoC interconnect.
- Converts one pipeline load/store into a single AXI4-Lite read or write transaction; generates byte strobes and replicated write data for SB/SH/SW.
- Aligns and sign/zero-extends load data.
- Holds the pipeline stall until the transaction completes.

Parameters:
- ADDR_WIDTH, 32, width of pipeline address and AXI AWADDR/ARADDR.

Ports:
- clk in 1: system clock
- rst in 1: synchronous reset, active-low
- mem_read in 1: load request from the MEM-stage instruction
- mem_write in 1: store request from the MEM-stage instruction
- addr in ADDR_WIDTH: byte address (ALU result)
- store_data in 32: rs2 data
- store_type in 2: 00 SB, 01 SH, 10 SW
- load_type in 3: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU
- stall out 1: freeze PC and all pipeline registers up to and including EX/MEM
- read_data out 32: aligned/extended load result
- bus_err out 1: one-cycle pulse on SLVERR/DECERR or misaligned access
- m_awaddr out ADDR_WIDTH, m_awvalid out 1, m_awready in 1
- m_wdata out 32, m_wstrb out 4, m_wvalid out 1, m_wready in 1
- m_bresp in 2, m_bvalid in 1, m_bready out 1
- m_araddr out ADDR_WIDTH, m_arvalid out 1, m_arready in 1
- m_rdata in 32, m_rresp in 2, m_rvalid in 1, m_rready out 1

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; all valid/ready outputs 0; read_data 0; bus_err 0; address/data/strobe registers 0.
- Mid-transaction reset aborts immediately; the interconnect shares rst.

FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.

IDLE:
- Request = mem_read | mem_write. If both are set, the write wins.
- On a legal request: latch word-aligned address {addr[ADDR_WIDTH-1:2],2'b00}, offset addr[1:0], load_type, wstrb and wdata; go to WR or RD_ADDR.
- stall = request & legal, combinational, in the accept cycle.
- Misaligned access (SH/LH/LHU with offset[0]=1; SW/LW with offset!=0): no bus transaction; bus_err pulses next cycle; stall=0; read_data unchanged.

Write data and strobe generation:
- SB: wdata = 4 copies of byte[7:0]; wstrb = 0001 << offset.
- SH: wdata = 2 copies of half[15:0]; wstrb = 0011 << (2*offset[1]).
- SW: wdata = store_data; wstrb = 1111.
- store_type 11: treated as SW.

WR:
- awvalid and wvalid both asserted. Each drops independently on its own handshake and must not drop before it.
- Go to WR_RESP when both handshakes have completed; same-cycle handshakes are allowed.

WR_RESP:
- bready=1; on bvalid, capture bresp and go to DONE.

RD_ADDR:
- arvalid=1; on arready, go to RD_DATA.

RD_DATA:
- rready=1; on rvalid, capture rdata and rresp and go to DONE.

DONE (exactly one cycle), then IDLE:
- stall=0.
- Loads: read_data registered from captured rdata using latched offset/load_type. LB/LBU select byte[offset]; LH/LHU select half[offset[1]]; sign- or zero-extend per type; load_type 101-111 passes the word unchanged.
- Response != OKAY: bus_err=1 and load read_data=0.

Stall and latency:
- stall=1 in every state except IDLE-without-request and DONE.
- Zero-wait slave: 3 stall cycles per access; the instruction leaves MEM at the end of DONE.
- read_data holds its value until the next completed load.
- A request present in the DONE cycle is ignored. It is the departing instruction; the next instruction is sampled in IDLE.

Test Plan:
- Zero-wait slave, LW addr=0x100, slave returns rdata=0xDEADBEEF -> arvalid at cycle 1 with araddr=0x100; stall high cycles 0-2, low cycle 3; read_data=0xDEADBEEF from cycle 4.
- SB addr=0x203 store_data=0x000000A5 -> awaddr=0x200, wstrb=1000, wdata=0xA5A5A5A5; SH addr=0x202 data=0x1234 -> wstrb=1100, wdata=0x12341234.
- LB/LBU addr=0x101 rdata=0x0000_80FF -> LB 0xFFFFFF80, LBU 0x00000080; LH addr=0x102 rdata=0x8001_0000 -> 0xFFFF8001.
- Slave delays: awready 3 cycles after wready, bvalid 2 cycles later -> awvalid held until handshake, wvalid dropped after its own; no duplicate transaction; stall released only in DONE.
- rresp=SLVERR on LW -> bus_err one-cycle pulse in DONE, read_data=0; SW addr=0x102 -> no AXI activity, stall=0, bus_err pulse.
- rst=0 asserted while in RD_DATA -> next cycle all valids/readys 0, state IDLE, stall=0, read_data=0.
